fetch_stage: RTL
================

Name: fetch_stage

Overview:
- Instruction fetch stage plus IF/ID pipeline register: owns the PC, reads instruction memory and presents one complete instruction per slot to decode.
- Instructions are 16-bit words. IADD, LDD and STD carry a second 16-bit immediate word, which a two-state FSM assembles before decode sees the instruction.
- Sits directly upstream of decode.
  - Consumes stallD from the load-use hazard logic.
  - Consumes the branch redirect from execute.
  - Drives the decoded opcode and source fields that the hazard logic compares.

Parameters:
- PC_W, 32, PC and instruction-memory address width (word addressed).
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_addr  out  PC_W  instruction-memory word address; equals the PC register.
- imem_rdata  in  16  instruction word at imem_addr, combinational (same-cycle) read.
- stallD  in  1  hold PC, FSM and IF/ID register.
- flush  in  1  branch taken: discard in-flight fetch and redirect.
- redirect_pc  in  PC_W  new PC when flush=1.
- de_valid  out  1  IF/ID slot holds a complete instruction.
- de_instr  out  16  instruction word.
- de_imm  out  16  immediate word; 0 for single-word instructions.
- de_pc  out  PC_W  address of de_instr's first word.
- de_opcode  out  7  de_instr[15:9].
- de_rdst  out  3  de_instr[8:6].
- de_rsrc1  out  3  de_instr[5:3].
- de_rsrc2  out  3  de_instr[2:0].

Behaviour:
- Reset (async):
  - pc=RESET_PC, state=S_OP.
  - de_valid=0, de_instr=0, de_imm=0, de_pc=0.
  - pending registers cleared.
- Two-word opcodes (need_imm):
  - 7'b0101000 (IADD)
  - 7'b1010??? (LDD)
  - 7'b1011??? (STD)
  - All other opcodes are single-word.
- Priority each rising edge: flush > stallD > normal advance.
- flush=1:
  - pc<=redirect_pc, state<=S_OP, de_valid<=0, pending discarded.
  - Applies in any state, including with stallD=1.
- stallD=1 (no flush): pc, state, pending and all de_* registers hold their values.
- S_OP, word = imem_rdata:
  - need_imm=0:
    - de_instr<=word, de_imm<=0, de_pc<=pc, de_valid<=1.
    - pc<=pc+1, stay in S_OP.
  - need_imm=1:
    - pend_instr<=word, pend_pc<=pc, pc<=pc+1.
    - de_valid<=0 (bubble into decode), state<=S_IMM.
- S_IMM:
  - de_instr<=pend_instr, de_imm<=imem_rdata, de_pc<=pend_pc, de_valid<=1.
  - pc<=pc+1, state<=S_OP.
- Latency: single-word instruction reaches decode 1 cycle after its address is on imem_addr; two-word instruction after 2 cycles.
- PC arithmetic: modulo 2^PC_W; all-ones wraps to 0 with no error.
- When de_valid=0, the de_* field outputs still reflect the register contents. Hazard logic qualifies its comparisons with de_valid.
- Reset asserted mid two-word fetch: pending word is lost and fetch restarts at RESET_PC.

Optional Feature:
- Macro FETCH_HALT_EN.
- Defined:
  - Opcode 7'b0000001 (HLT) fetched in S_OP is passed to decode as a normal single-word instruction.
  - FSM then enters S_HALT: pc holds, imem_addr constant, de_valid<=0 every subsequent cycle.
  - Only flush (to redirect_pc, S_OP) or rst leaves S_HALT.
  - stallD in S_HALT holds de_* as usual.
- Undefined: no S_HALT state; HLT is fetched as an ordinary single-word instruction and pc keeps incrementing.

Test Plan:
- Reset release, memory words 0..2 = 16'h4000 (ADD), 16'h4E48, 16'h0000 -> de_pc 0, 1, 2 on consecutive cycles; de_valid=1 from first edge after reset; de_imm=0.
- IADD 16'h5048 at addr 4, imm 16'h1234 at addr 5, ADD at addr 6:
  - Cycle after addr 4: de_valid=0.
  - Next cycle: de_instr=16'h5048, de_imm=16'h1234, de_pc=4.
  - Next cycle: de_pc=6.
- stallD=1 for 2 cycles while de_instr=LDD at pc 8 -> imem_addr and all de_* constant; on release the FSM resumes exactly where it stopped, with no skipped or duplicated word.
- flush=1, redirect_pc=32'h40, asserted while in S_IMM (and again with stallD=1 simultaneously):
  - Next cycle: imem_addr=32'h40, de_valid=0, pending IADD never appears.
  - Following cycle: de_pc=32'h40.
- Async rst pulse mid-cycle during S_IMM -> outputs clear immediately without a clock edge; after release imem_addr=RESET_PC.
- FETCH_HALT_EN defined, HLT 16'h0200 at addr 3:
  - de_instr=16'h0200 once, then de_valid=0.
  - imem_addr stays 4 for 10 cycles.
  - flush to 32'h10 resumes fetch at 32'h10.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: instruction-memory port, hazard/redirect controls and the IF/ID outputs.
// The master modport is the fetch stage; the slave modport is memory plus decode/hazard logic.
interface fetch_stage_if #(
  parameter int PC_W = 32
);
  logic [PC_W-1:0] imem_addr;
  logic [15:0]     imem_rdata;
  logic            stallD;
  logic            flush;
  logic [PC_W-1:0] redirect_pc;
  logic            de_valid;
  logic [15:0]     de_instr;
  logic [15:0]     de_imm;
  logic [PC_W-1:0] de_pc;
  logic [6:0]      de_opcode;
  logic [2:0]      de_rdst;
  logic [2:0]      de_rsrc1;
  logic [2:0]      de_rsrc2;

  modport master (
    output imem_addr,
    input  imem_rdata,
    input  stallD,
    input  flush,
    input  redirect_pc,
    output de_valid,
    output de_instr,
    output de_imm,
    output de_pc,
    output de_opcode,
    output de_rdst,
    output de_rsrc1,
    output de_rsrc2
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    output stallD,
    output flush,
    output redirect_pc,
    input  de_valid,
    input  de_instr,
    input  de_imm,
    input  de_pc,
    input  de_opcode,
    input  de_rdst,
    input  de_rsrc1,
    input  de_rsrc2
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch plus IF/ID register; assembles two-word IADD/LDD/STD before decode.
// Optional HLT halting is enabled by defining FETCH_HALT_EN.
module fetch_stage #(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
  input  logic         clk,
  input  logic         rst,
  fetch_stage_if.master bus
);

  localparam logic [1:0] S_OP  = 2'd0;
  localparam logic [1:0] S_IMM = 2'd1;
`ifdef FETCH_HALT_EN
  localparam logic [1:0] S_HALT = 2'd2;
  localparam logic [6:0] OP_HLT = 7'b0000001;
`endif
  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  logic [PC_W-1:0] pc_r;
  logic [1:0]      state_r;
  logic [15:0]     pend_instr_r;
  logic [PC_W-1:0] pend_pc_r;
  logic            de_valid_r;
  logic [15:0]     de_instr_r;
  logic [15:0]     de_imm_r;
  logic [PC_W-1:0] de_pc_r;
  logic [15:0]     word_s;
  logic [PC_W-1:0] pc_next_s;

  function automatic logic need_imm(input logic [6:0] op);
    need_imm = (op == 7'b0101000) || (op[6:3] == 4'b1010) || (op[6:3] == 4'b1011);
  endfunction

  assign word_s    = bus.imem_rdata;
  assign pc_next_s = pc_r + PC_ONE;

  // PC, fetch FSM, pending first word and IF/ID register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_r         <= RESET_PC;
      state_r      <= S_OP;
      pend_instr_r <= 16'h0000;
      pend_pc_r    <= {PC_W{1'b0}};
      de_valid_r   <= 1'b0;
      de_instr_r   <= 16'h0000;
      de_imm_r     <= 16'h0000;
      de_pc_r      <= {PC_W{1'b0}};
    end else if (bus.flush) begin
      pc_r         <= bus.redirect_pc;
      state_r      <= S_OP;
      pend_instr_r <= 16'h0000;
      pend_pc_r    <= {PC_W{1'b0}};
      de_valid_r   <= 1'b0;
    end else if (bus.stallD) begin
      pc_r <= pc_r;
    end else begin
      case (state_r)
        S_OP: begin
          pc_r <= pc_next_s;
          if (need_imm(word_s[15:9])) begin
            pend_instr_r <= word_s;
            pend_pc_r    <= pc_r;
            de_valid_r   <= 1'b0;
            state_r      <= S_IMM;
          end else begin
            de_instr_r <= word_s;
            de_imm_r   <= 16'h0000;
            de_pc_r    <= pc_r;
            de_valid_r <= 1'b1;
`ifdef FETCH_HALT_EN
            state_r    <= (word_s[15:9] == OP_HLT) ? S_HALT : S_OP;
`else
            state_r    <= S_OP;
`endif
          end
        end
        S_IMM: begin
          de_instr_r <= pend_instr_r;
          de_imm_r   <= word_s;
          de_pc_r    <= pend_pc_r;
          de_valid_r <= 1'b1;
          pc_r       <= pc_next_s;
          state_r    <= S_OP;
        end
`ifdef FETCH_HALT_EN
        S_HALT: begin
          // Parked until a redirect; only flush or rst can leave
          de_valid_r <= 1'b0;
          pc_r       <= pc_r;
        end
`endif
        default: begin
          state_r    <= S_OP;
          de_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_addr = pc_r;
  assign bus.de_valid  = de_valid_r;
  assign bus.de_instr  = de_instr_r;
  assign bus.de_imm    = de_imm_r;
  assign bus.de_pc     = de_pc_r;
  assign bus.de_opcode = de_instr_r[15:9];
  assign bus.de_rdst   = de_instr_r[8:6];
  assign bus.de_rsrc1  = de_instr_r[5:3];
  assign bus.de_rsrc2  = de_instr_r[2:0];

endmodule
